// File: rtl/pixel_unpacker_if.sv
// pixel_unpacker_if: 32-bit AXI4-Stream pixel beat bus (tdata/tkeep/tlast/tuser/tvalid/tready)
interface pixel_unpacker_if;
  logic [31:0] tdata;
  logic [3:0]  tkeep;
  logic        tlast;
  logic        tuser;
  logic        tvalid;
  logic        tready;
  modport master(output tdata, tkeep, tlast, tuser, tvalid, input tready);
  modport slave(input tdata, tkeep, tlast, tuser, tvalid, output tready);
endinterface

// File: rtl/pixel_unpacker.sv
// pixel_unpacker: unpacks 3x32-bit stream beats into 4x24-bit {r,g,b} pixels with sof/eol and sticky err
// ports: aclk/aresetn (sync, active-low), in_stream (slave beat bus), r/g/b/sof/eol/out_valid/out_ready pixel out, err
module pixel_unpacker #(
  parameter int X_SIZE = 640
) (
  input  logic             aclk,
  input  logic             aresetn,
  pixel_unpacker_if.slave  in_stream,
  output logic [7:0]       r,
  output logic [7:0]       g,
  output logic [7:0]       b,
  output logic             sof,
  output logic             eol,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             err
);
  localparam int XW = $clog2(X_SIZE);
  localparam logic [XW-1:0] X_LAST = XW'(X_SIZE - 1);
  localparam logic [1:0] PH0 = 2'd0;
  localparam logic [1:0] PH1 = 2'd1;
  localparam logic [1:0] PH2 = 2'd2;
  localparam logic [1:0] PH3 = 2'd3;
  logic [1:0]    phase_q, phase_d, eph;
  logic [23:0]   res_q, res_d, pix_q, pix_d, pix;
  logic [XW-1:0] x_q, x_d, xcur;
  logic          last_q, last_d, sof_q, sof_d, eol_q, eol_d, ov_q, ov_d, err_q, err_d;
  logic          load_ok, acc, emit, cut, pix_eol, beat_err;
  logic [31:0]   d;
  assign in_stream.tready = aresetn & load_ok & (phase_q != PH3);
  // tuser forces a beat to decode as ph0; a ph0/ph1 tlast cuts the line short
  always_comb begin
    d        = in_stream.tdata;
    load_ok  = !ov_q | out_ready;
    acc      = in_stream.tvalid & in_stream.tready;
    emit     = load_ok & (phase_q == PH3);
    eph      = in_stream.tuser ? PH0 : phase_q;
    cut      = in_stream.tlast & ~eph[1];
    xcur     = (acc & in_stream.tuser) ? '0 : x_q;
    pix      = !acc ? res_q :
               eph == PH0 ? d[23:0] :
               eph == PH1 ? {d[15:0], res_q[7:0]} : {d[7:0], res_q[15:0]};
    pix_eol  = (xcur == X_LAST) | (acc ? cut : last_q);
    beat_err = (in_stream.tkeep != 4'hF) | (in_stream.tuser & (phase_q != PH0)) | cut | (xcur == X_LAST);
    err_d    = err_q | (acc & beat_err) | (emit & (last_q != (x_q == X_LAST)));
    ov_d     = (acc | emit) | (ov_q & ~out_ready);
    pix_d    = (acc | emit) ? pix : pix_q;
    sof_d    = (acc | emit) ? (acc & in_stream.tuser) : sof_q;
    eol_d    = (acc | emit) ? pix_eol : eol_q;
    x_d      = (acc | emit) ? (pix_eol ? '0 : xcur + 1'b1) : x_q;
    last_d   = acc ? in_stream.tlast : last_q;
    phase_d  = emit ? PH0 : !acc ? phase_q : cut ? PH0 : eph + 2'd1;
    res_d    = emit ? '0 : !acc ? res_q : cut ? '0 :
               eph == PH0 ? {16'h0, d[31:24]} :
               eph == PH1 ? {8'h0, d[31:16]} : d[31:8];
  end
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      phase_q <= '0;
      res_q   <= '0;
      pix_q   <= '0;
      x_q     <= '0;
      last_q  <= 1'b0;
      sof_q   <= 1'b0;
      eol_q   <= 1'b0;
      ov_q    <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      phase_q <= phase_d;
      res_q   <= res_d;
      pix_q   <= pix_d;
      x_q     <= x_d;
      last_q  <= last_d;
      sof_q   <= sof_d;
      eol_q   <= eol_d;
      ov_q    <= ov_d;
      err_q   <= err_d;
    end
  end
  assign r         = pix_q[23:16];
  assign g         = pix_q[15:8];
  assign b         = pix_q[7:0];
  assign sof       = sof_q;
  assign eol       = eol_q;
  assign out_valid = ov_q;
  assign err       = err_q;
endmodule

// File: tb/tb_pixel_unpacker.sv
// tb_pixel_unpacker: directed table plus stream sequences for pixel_unpacker
module tb_pixel_unpacker;
  logic aclk = 1'b0;
  logic aresetn = 1'b0;
  logic out_ready = 1'b1;
  logic [7:0] r, g, b;
  logic sof, eol, out_valid, err;
  int checks = 0;
  int errors = 0;
  pixel_unpacker_if in_stream ();
  pixel_unpacker #(.X_SIZE(640)) dut (
    .aclk(aclk), .aresetn(aresetn), .in_stream(in_stream),
    .r(r), .g(g), .b(b), .sof(sof), .eol(eol),
    .out_valid(out_valid), .out_ready(out_ready), .err(err)
  );
  always #5 aclk = ~aclk;
  typedef struct {
    logic rst, vld;
    logic [3:0] keep;
    logic [31:0] data;
    logic user, last, rdy;
    logic e_trdy, e_ov;
    logic [23:0] e_pix;
    logic e_sof, e_eol, e_err;
  } vec_t;
  vec_t tbl[$];
  function automatic vec_t mk(logic rst, logic vld, logic [3:0] keep, logic [31:0] data, logic user,
                              logic last, logic e_trdy, logic e_ov, logic [23:0] e_pix,
                              logic e_sof, logic e_eol, logic e_err);
    vec_t v;
    v.rst = rst; v.vld = vld; v.keep = keep; v.data = data; v.user = user; v.last = last; v.rdy = 1'b1;
    v.e_trdy = e_trdy; v.e_ov = e_ov; v.e_pix = e_pix; v.e_sof = e_sof; v.e_eol = e_eol; v.e_err = e_err;
    return v;
  endfunction
  function automatic logic [23:0] exp_pix(int p);
    return {8'(3 * p + 2), 8'(3 * p + 1), 8'(3 * p)};
  endfunction
  function automatic logic [31:0] beat(int j);
    return {8'(4 * j + 3), 8'(4 * j + 2), 8'(4 * j + 1), 8'(4 * j)};
  endfunction
  task automatic run_stream(input string nm, input int nbeats, input int npix, input bit use_last,
                            input int st0, input int stlen);
    int j, p, eols;
    j = 0; p = 0; eols = 0;
    @(negedge aclk);
    aresetn = 1'b0;
    in_stream.tvalid = 1'b0;
    @(posedge aclk);
    for (int cyc = 0; cyc < 3000 && p < npix; cyc++) begin
      @(negedge aclk);
      aresetn = 1'b1;
      in_stream.tvalid = (j < nbeats);
      in_stream.tdata = beat(j);
      in_stream.tkeep = 4'hF;
      in_stream.tuser = (j == 0);
      in_stream.tlast = use_last && (j == nbeats - 1);
      out_ready = !(cyc >= st0 && cyc < st0 + stlen);
      #1;
      if (!out_ready && out_valid) begin
        checks++;
        if (in_stream.tready || {r, g, b} != exp_pix(p)) begin
          errors++;
          $display("FAIL %s stall px%0d: tready=%0b rgb=%h, required tready=0 rgb=%h", nm, p, in_stream.tready, {r, g, b}, exp_pix(p));
        end
      end
      if (out_valid && out_ready) begin
        checks++;
        if ({r, g, b, sof, eol} != {exp_pix(p), p == 0, (p % 640) == 639}) begin
          errors++;
          $display("FAIL %s px%0d: rgb=%h sof=%0b eol=%0b, required rgb=%h sof=%0b eol=%0b", nm, p, {r, g, b}, sof, eol,
                   exp_pix(p), p == 0, (p % 640) == 639);
        end
        eols += int'(eol);
        p++;
      end
      if (in_stream.tvalid && in_stream.tready) j++;
      @(posedge aclk);
    end
    #1;
    in_stream.tvalid = 1'b0;
    out_ready = 1'b1;
    checks++;
    if (p != npix || j != nbeats || err || eols != npix / 640) begin
      errors++;
      $display("FAIL %s end: pixels=%0d beats=%0d err=%0b eols=%0d, required %0d %0d 0 %0d", nm, p, j, err, eols,
               npix, nbeats, npix / 640);
    end
  endtask
  initial begin
    in_stream.tvalid = 1'b0; in_stream.tdata = '0; in_stream.tkeep = 4'hF;
    in_stream.tuser = 1'b0; in_stream.tlast = 1'b0;
    tbl.push_back(mk(1, 0, 4'hF, 32'h0,        0, 0, 0, 0, 24'h000000, 0, 0, 0));
    tbl.push_back(mk(0, 1, 4'hF, 32'h44332211, 1, 0, 1, 1, 24'h332211, 1, 0, 0));
    tbl.push_back(mk(0, 1, 4'hF, 32'h88776655, 0, 0, 1, 1, 24'h665544, 0, 0, 0));
    tbl.push_back(mk(0, 1, 4'hF, 32'hCCBBAA99, 0, 0, 1, 1, 24'h998877, 0, 0, 0));
    tbl.push_back(mk(0, 1, 4'hF, 32'hDEADBEEF, 0, 0, 0, 1, 24'hCCBBAA, 0, 0, 0));
    tbl.push_back(mk(0, 1, 4'hF, 32'hDEADBEEF, 0, 0, 1, 1, 24'hADBEEF, 0, 0, 0));
    tbl.push_back(mk(0, 0, 4'hF, 32'h0,        0, 0, 1, 0, 24'hADBEEF, 0, 0, 0));
    tbl.push_back(mk(0, 1, 4'hF, 32'h03020100, 1, 0, 1, 1, 24'h020100, 1, 0, 1));
    tbl.push_back(mk(0, 1, 4'hF, 32'h07060504, 0, 0, 1, 1, 24'h050403, 0, 0, 1));
    tbl.push_back(mk(0, 0, 4'hF, 32'h0,        0, 0, 1, 0, 24'h050403, 0, 0, 1));
    tbl.push_back(mk(1, 0, 4'hF, 32'h0,        0, 0, 0, 0, 24'h000000, 0, 0, 0));
    tbl.push_back(mk(0, 1, 4'hF, 32'h13121110, 1, 0, 1, 1, 24'h121110, 1, 0, 0));
    tbl.push_back(mk(0, 1, 4'hF, 32'h17161514, 0, 1, 1, 1, 24'h151413, 0, 1, 1));
    tbl.push_back(mk(0, 1, 4'hF, 32'h1B1A1918, 0, 0, 1, 1, 24'h1A1918, 0, 0, 1));
    tbl.push_back(mk(0, 0, 4'hF, 32'h0,        0, 0, 1, 0, 24'h1A1918, 0, 0, 1));
    tbl.push_back(mk(1, 0, 4'hF, 32'h0,        0, 0, 0, 0, 24'h000000, 0, 0, 0));
    tbl.push_back(mk(0, 1, 4'h7, 32'h23222120, 1, 0, 1, 1, 24'h222120, 1, 0, 1));
    tbl.push_back(mk(1, 0, 4'hF, 32'h0,        0, 0, 0, 0, 24'h000000, 0, 0, 0));
    tbl.push_back(mk(0, 1, 4'hF, 32'h33323130, 1, 0, 1, 1, 24'h323130, 1, 0, 0));
    tbl.push_back(mk(0, 1, 4'hF, 32'h37363534, 0, 0, 1, 1, 24'h353433, 0, 0, 0));
    tbl.push_back(mk(1, 1, 4'hF, 32'h3B3A3938, 0, 0, 0, 0, 24'h000000, 0, 0, 0));
    tbl.push_back(mk(0, 1, 4'hF, 32'h43424140, 1, 0, 1, 1, 24'h424140, 1, 0, 0));
    tbl.push_back(mk(0, 1, 4'hF, 32'h47464544, 0, 0, 1, 1, 24'h454443, 0, 0, 0));
    foreach (tbl[i]) begin
      @(negedge aclk);
      aresetn = !tbl[i].rst;
      in_stream.tvalid = tbl[i].vld;
      in_stream.tkeep = tbl[i].keep;
      in_stream.tdata = tbl[i].data;
      in_stream.tuser = tbl[i].user;
      in_stream.tlast = tbl[i].last;
      out_ready = tbl[i].rdy;
      #1;
      checks++;
      if (in_stream.tready !== tbl[i].e_trdy) begin
        errors++;
        $display("FAIL row%0d tready: got %0b, required %0b", i, in_stream.tready, tbl[i].e_trdy);
      end
      @(posedge aclk);
      #1;
      checks++;
      if ({out_valid, r, g, b, sof, eol, err} !== {tbl[i].e_ov, tbl[i].e_pix, tbl[i].e_sof, tbl[i].e_eol, tbl[i].e_err}) begin
        errors++;
        $display("FAIL row%0d outputs: ov=%0b rgb=%h sof=%0b eol=%0b err=%0b, required ov=%0b rgb=%h sof=%0b eol=%0b err=%0b",
                 i, out_valid, {r, g, b}, sof, eol, err, tbl[i].e_ov, tbl[i].e_pix, tbl[i].e_sof, tbl[i].e_eol, tbl[i].e_err);
      end
    end
    run_stream("line640", 480, 640, 1'b1, -1, 0);
    run_stream("stall", 6, 8, 1'b0, 2, 5);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
